// File: rtl/tm1637_pkg.sv
// Shared constants for the TM1637 bus snoop: command classes, segment patterns, FSM states.
package tm1637_pkg;

  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_CTRL = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;
  localparam int FIXED_ADDR_BIT = 2;

  // Segment order: bit0=a ... bit6=g
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h67;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } snoop_state_t;

endpackage

// File: rtl/tm1637_seg_snoop_seg_to_hex.sv
// Combinational 7-segment pattern to hex nibble decoder; unknown patterns give hex 0, known 0.
module seg_to_hex
  import tm1637_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       known
);

  always_comb begin
    hex   = 4'h0;
    known = 1'b1;
    case (seg)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: known = 1'b0;
    endcase
  end

endmodule

// File: rtl/tm1637_seg_snoop.sv
// Passive TM1637 bus receiver: frames bytes, tracks mode/address, decodes display bytes to hex.
// Optional per-address shadow registers are enabled with SEG_SNOOP_SHADOW_EN.
module tm1637_seg_snoop
  import tm1637_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tm_clk,
  input  logic                    tm_dio,
  output logic                    digit_valid,
  output logic [2:0]              digit_addr,
  output logic [3:0]              digit_hex,
  output logic                    digit_known,
  output logic                    digit_dp,
  output logic                    frame_err
`ifdef SEG_SNOOP_SHADOW_EN
  ,
  output logic [4*NUM_DIGITS-1:0] shadow_hex,
  output logic [NUM_DIGITS-1:0]   shadow_known
`endif
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dio_sync;
  logic                   clk_prev;
  logic                   dio_prev;
  logic                   clk_s;
  logic                   dio_s;
  logic                   start_det;
  logic                   stop_det;
  logic                   clk_rise;

  snoop_state_t state;
  logic         fixed_mode;
  logic         cmd_done;
  logic [2:0]   addr;
  logic [6:0]   shreg;
  logic [3:0]   bit_cnt;
  logic [7:0]   byte_next;
  logic [2:0]   addr_load;
  logic [2:0]   addr_inc;
  logic         partial;
  logic [3:0]   dec_hex;
  logic         dec_known;

  // Synchronizers reset to the idle-high bus level so release from reset makes no edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dio_sync <= '1;
      clk_prev <= 1'b1;
      dio_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], tm_clk};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], tm_dio};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      dio_prev <= dio_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign dio_s     = dio_sync[SYNC_STAGES-1];
  assign start_det = clk_s & dio_prev & ~dio_s;
  assign stop_det  = clk_s & ~dio_prev & dio_s;
  assign clk_rise  = clk_s & ~clk_prev;

  // Bytes arrive LSB first; shreg holds the first seven bits once the count reaches 7.
  assign byte_next = {dio_s, shreg};
  assign addr_load = 3'(int'(byte_next[2:0]) % NUM_DIGITS);
  assign addr_inc  = (addr == 3'(NUM_DIGITS - 1)) ? 3'd0 : addr + 3'd1;
  assign partial   = (bit_cnt != 4'd0) && (bit_cnt != 4'd8);

  seg_to_hex u_seg_to_hex (
    .seg   (byte_next[6:0]),
    .hex   (dec_hex),
    .known (dec_known)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fixed_mode  <= 1'b0;
      cmd_done    <= 1'b0;
      addr        <= 3'd0;
      shreg       <= 7'd0;
      bit_cnt     <= 4'd0;
      digit_valid <= 1'b0;
      digit_addr  <= 3'd0;
      digit_hex   <= 4'd0;
      digit_known <= 1'b0;
      digit_dp    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (stop_det) begin
        frame_err <= partial;
        state     <= IDLE;
        bit_cnt   <= 4'd0;
        shreg     <= 7'd0;
      end else if (start_det) begin
        frame_err <= partial;
        state     <= CMD;
        cmd_done  <= 1'b0;
        bit_cnt   <= 4'd0;
        shreg     <= 7'd0;
      end else if (clk_rise && state != IDLE) begin
        if (bit_cnt == 4'd8) begin
          // ACK clock: the byte was already consumed on the previous rise
          bit_cnt <= 4'd0;
        end else begin
          shreg   <= byte_next[7:1];
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            case (state)
              CMD: begin
                // Only the first byte of a frame is a command; the rest are ignored.
                if (!cmd_done) begin
                  cmd_done <= 1'b1;
                  case (byte_next[7:6])
                    CMD_DATA: fixed_mode <= byte_next[FIXED_ADDR_BIT];
                    CMD_ADDR: begin
                      addr  <= addr_load;
                      state <= DATA;
                    end
                    default: ;
                  endcase
                end
              end
              DATA: begin
                digit_valid <= 1'b1;
                digit_addr  <= addr;
                digit_hex   <= dec_hex;
                digit_known <= dec_known;
                digit_dp    <= byte_next[7];
                if (!fixed_mode) addr <= addr_inc;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

`ifdef SEG_SNOOP_SHADOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_hex   <= '0;
      shadow_known <= '0;
    end else if (digit_valid) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_addr == 3'(i)) begin
          shadow_hex[4*i +: 4] <= digit_hex;
          shadow_known[i]      <= digit_known;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_tm1637_seg_snoop.sv
// Directed bench for tm1637_seg_snoop: bus driver tasks, expected-digit queue, monitor, report.
module tb_tm1637_seg_snoop;

  localparam int PH = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tm_clk = 1'b1;
  logic       tm_dio = 1'b1;
  logic       digit_valid;
  logic [2:0] digit_addr;
  logic [3:0] digit_hex;
  logic       digit_known;
  logic       digit_dp;
  logic       frame_err;
`ifdef SEG_SNOOP_SHADOW_EN
  logic [23:0] shadow_hex;
  logic [5:0]  shadow_known;
`endif

  logic [8:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int err_exp = 0;

  always #5 clk = ~clk;

  tm1637_seg_snoop #(.NUM_DIGITS(6), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tm_clk       (tm_clk),
    .tm_dio       (tm_dio),
    .digit_valid  (digit_valid),
    .digit_addr   (digit_addr),
    .digit_hex    (digit_hex),
    .digit_known  (digit_known),
    .digit_dp     (digit_dp),
    .frame_err    (frame_err)
`ifdef SEG_SNOOP_SHADOW_EN
    ,
    .shadow_hex   (shadow_hex),
    .shadow_known (shadow_known)
`endif
  );

  task automatic expect_digit(input int a, input int h, input bit k, input bit d);
    exp_q.push_back({3'(a), 4'(h), k, d});
  endtask

  // Bus idle is CLK=1, DIO=1; start leaves CLK high and DIO low.
  task automatic bus_start();
    tm_clk = 1'b1;
    tm_dio = 1'b1;
    #PH;
    tm_dio = 1'b0;
    #PH;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tm_clk = 1'b0;
      #PH;
      tm_dio = b[i];
      #PH;
      tm_clk = 1'b1;
      #PH;
    end
  endtask

  // Ends on the ACK clock high with DIO low, so a stop needs no extra clock.
  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
    tm_clk = 1'b0;
    #PH;
    tm_dio = 1'b0;
    #PH;
    tm_clk = 1'b1;
    #PH;
  endtask

  task automatic bus_stop();
    if (tm_clk == 1'b0 || tm_dio == 1'b1) begin
      tm_clk = 1'b0;
      #PH;
      tm_dio = 1'b0;
      #PH;
      tm_clk = 1'b1;
      #PH;
    end
    tm_dio = 1'b1;
    #(2*PH);
  endtask

  task automatic cmd_frame(input logic [7:0] b);
    bus_start();
    send_byte(b);
    bus_stop();
  endtask

  task automatic check_outputs_zero(input string name);
    logic [10:0] got;
    got = {digit_valid, digit_addr, digit_hex, digit_known, digit_dp, frame_err};
    total++;
    if (got !== 11'd0) begin
      bad++;
      $display("FAIL %s outputs got=%h want=000", name, got);
    end
  endtask

  task automatic monitor_loop();
    logic [8:0] got;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) err_seen++;
      if (digit_valid === 1'b1) begin
        got = {digit_addr, digit_hex, digit_known, digit_dp};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL digit_unexpected got addr=%0d hex=%h known=%b dp=%b",
                   digit_addr, digit_hex, digit_known, digit_dp);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL digit got addr=%0d hex=%h known=%b dp=%b want addr=%0d hex=%h known=%b dp=%b",
                     got[8:6], got[5:2], got[1], got[0], e[8:6], e[5:2], e[1], e[0]);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_initial");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Auto-increment from address 0 across six digits
    cmd_frame(8'h40);
    for (int i = 0; i < 6; i++) expect_digit(i, i, 1'b1, 1'b0);
    bus_start();
    send_byte(8'hC0);
    send_byte(8'h3F); send_byte(8'h06); send_byte(8'h5B);
    send_byte(8'h4F); send_byte(8'h66); send_byte(8'h6D);
    bus_stop();

    // Fixed address mode holds address 3 across frames
    cmd_frame(8'h44);
    expect_digit(3, 8, 1'b1, 1'b1);
    bus_start(); send_byte(8'hC3); send_byte(8'hFF); bus_stop();
    expect_digit(3, 7, 1'b1, 1'b0);
    bus_start(); send_byte(8'hC3); send_byte(8'h07); bus_stop();

    // Auto-increment wraps 5 -> 0
    cmd_frame(8'h40);
    expect_digit(5, 8, 1'b1, 1'b0);
    expect_digit(0, 9, 1'b1, 1'b0);
    bus_start(); send_byte(8'hC5); send_byte(8'h7F); send_byte(8'h67); bus_stop();

    // Unknown patterns, remaining letters, dp with blank segments
    expect_digit(0, 0, 1'b0, 1'b0);
    expect_digit(1, 4'hB, 1'b1, 1'b0);
    expect_digit(2, 4'hD, 1'b1, 1'b0);
    expect_digit(3, 4'hE, 1'b1, 1'b0);
    expect_digit(4, 4'hF, 1'b1, 1'b0);
    expect_digit(5, 0, 1'b0, 1'b1);
    bus_start();
    send_byte(8'hC0);
    send_byte(8'h49); send_byte(8'h7C); send_byte(8'h5E);
    send_byte(8'h79); send_byte(8'h71); send_byte(8'h80);
    bus_stop();

    // Display-control frame: trailing bytes produce nothing
    bus_start(); send_byte(8'h8F); send_byte(8'h3F); bus_stop();

    // Stop mid data byte
    err_exp++;
    bus_start(); send_byte(8'hC0); send_bits(8'h06, 4); bus_stop();
    expect_digit(2, 1, 1'b1, 1'b0);
    bus_start(); send_byte(8'hC2); send_byte(8'h06); bus_stop();

    // Reset during the third data byte clears outputs and mode
    cmd_frame(8'h44);
    expect_digit(2, 6, 1'b1, 1'b0);
    expect_digit(2, 4'hA, 1'b1, 1'b0);
    bus_start(); send_byte(8'hC2); send_byte(8'h7D); send_byte(8'h77);
    send_bits(8'h3F, 4);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_midframe");
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    bus_stop();
    expect_digit(1, 4'hC, 1'b1, 1'b0);
    expect_digit(2, 3, 1'b1, 1'b0);
    bus_start(); send_byte(8'hC1); send_byte(8'h39); send_byte(8'h4F); bus_stop();

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    total++;
    if (err_seen != err_exp) begin
      bad++;
      $display("FAIL frame_err count got=%0d want=%0d", err_seen, err_exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
